// File: rtl/sram_dp_tiled.sv
// True dual-port SRAM built from MACRO_WIDTH-wide behavioural tiles sharing address/control.
// Byte masks, A-wins write collisions, read-old on read/write collisions, zero-fill after reset.
module sram_dp_tiled #(
    parameter int WIDTH       = 256,
    parameter int DEPTH       = 64,
    parameter int MACRO_WIDTH = 64,
    parameter int OUT_REG     = 1,
    localparam int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int NB         = WIDTH / 8
) (
    input  logic             clk,
    input  logic             rst,
    output logic             ready,
    input  logic             enable_a_n,
    input  logic             write_enable_a_n,
    input  logic [NB-1:0]    mask_a,
    input  logic [AW-1:0]    address_a,
    input  logic [WIDTH-1:0] data_a,
    output logic [WIDTH-1:0] q_a,
    output logic             q_a_valid,
    input  logic             enable_b_n,
    input  logic             write_enable_b_n,
    input  logic [NB-1:0]    mask_b,
    input  logic [AW-1:0]    address_b,
    input  logic [WIDTH-1:0] data_b,
    output logic [WIDTH-1:0] q_b,
    output logic             q_b_valid
);

    localparam int NT = WIDTH / MACRO_WIDTH;
    localparam int MB = MACRO_WIDTH / 8;

    if ((WIDTH % 8 != 0) || (WIDTH % MACRO_WIDTH != 0) || (MACRO_WIDTH % 8 != 0) || (DEPTH < 2)) begin : g_param_err
        $fatal(1, "sram_dp_tiled: illegal WIDTH/MACRO_WIDTH/DEPTH combination");
    end

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_e;

    state_e          state_q;
    logic [AW-1:0]   fill_cnt_q;
    logic            ready_q;

    logic            fill_we_s;
    logic            ok_a_s, ok_b_s;
    logic            rd_a_s, rd_b_s;
    logic            wr_a_s, wr_b_s;
    logic            rd_v_a_q, rd_v_b_q;
    logic [WIDTH-1:0] rd_word_a_s, rd_word_b_s;

    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (int'({1'b0, a}) < DEPTH) ? 1'b1 : 1'b0;
    endfunction

    assign ready     = ready_q;
    assign fill_we_s = (state_q == ST_INIT) && !rst;
    assign ok_a_s    = addr_ok(address_a);
    assign ok_b_s    = addr_ok(address_b);
    assign rd_a_s    = ready_q && !enable_a_n && write_enable_a_n;
    assign rd_b_s    = ready_q && !enable_b_n && write_enable_b_n;
    assign wr_a_s    = ready_q && !enable_a_n && !write_enable_a_n && ok_a_s && !rst;
    assign wr_b_s    = ready_q && !enable_b_n && !write_enable_b_n && ok_b_s && !rst;

    // Zero-fill sequencer: one word per cycle, then hold READY until reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_INIT;
            fill_cnt_q <= '0;
            ready_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    fill_cnt_q <= fill_cnt_q + AW'(1);
                    if (fill_cnt_q == AW'(DEPTH - 1)) begin
                        state_q <= ST_READY;
                        ready_q <= 1'b1;
                    end
                end
                ST_READY: begin
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q    <= ST_INIT;
                    fill_cnt_q <= '0;
                    ready_q    <= 1'b0;
                end
            endcase
        end
    end

    for (genvar t = 0; t < NT; t++) begin : g_tile
        logic [MACRO_WIDTH-1:0] mem_q [DEPTH];
        logic [MACRO_WIDTH-1:0] rd_a_q, rd_b_q;

        // B bytes are scheduled first so A overrides them on a shared address
        always_ff @(posedge clk) begin
            if (fill_we_s) begin
                mem_q[fill_cnt_q] <= '0;
            end else begin
                for (int b = 0; b < MB; b++) begin
                    if (wr_b_s && mask_b[t*MB + b])
                        mem_q[address_b][b*8 +: 8] <= data_b[t*MACRO_WIDTH + b*8 +: 8];
                end
                for (int b = 0; b < MB; b++) begin
                    if (wr_a_s && mask_a[t*MB + b])
                        mem_q[address_a][b*8 +: 8] <= data_a[t*MACRO_WIDTH + b*8 +: 8];
                end
            end
        end

        // Read stage samples the array before this edge's writes land
        always_ff @(posedge clk) begin
            if (rst) begin
                rd_a_q <= '0;
                rd_b_q <= '0;
            end else begin
                if (rd_a_s) rd_a_q <= ok_a_s ? mem_q[address_a] : '0;
                if (rd_b_s) rd_b_q <= ok_b_s ? mem_q[address_b] : '0;
            end
        end

        assign rd_word_a_s[t*MACRO_WIDTH +: MACRO_WIDTH] = rd_a_q;
        assign rd_word_b_s[t*MACRO_WIDTH +: MACRO_WIDTH] = rd_b_q;
    end

    // First-stage read valids
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_v_a_q <= 1'b0;
            rd_v_b_q <= 1'b0;
        end else begin
            rd_v_a_q <= rd_a_s;
            rd_v_b_q <= rd_b_s;
        end
    end

    if (OUT_REG != 0) begin : g_oreg
        logic [WIDTH-1:0] q_a_q, q_b_q;
        logic             q_a_valid_q, q_b_valid_q;

        // Output stage captures data only when a read completes, otherwise holds
        always_ff @(posedge clk) begin
            if (rst) begin
                q_a_q       <= '0;
                q_b_q       <= '0;
                q_a_valid_q <= 1'b0;
                q_b_valid_q <= 1'b0;
            end else begin
                q_a_valid_q <= rd_v_a_q;
                q_b_valid_q <= rd_v_b_q;
                if (rd_v_a_q) q_a_q <= rd_word_a_s;
                if (rd_v_b_q) q_b_q <= rd_word_b_s;
            end
        end

        assign q_a       = q_a_q;
        assign q_b       = q_b_q;
        assign q_a_valid = q_a_valid_q;
        assign q_b_valid = q_b_valid_q;
    end else begin : g_noreg
        assign q_a       = rd_word_a_s;
        assign q_b       = rd_word_b_s;
        assign q_a_valid = rd_v_a_q;
        assign q_b_valid = rd_v_b_q;
    end

endmodule

// File: tb/tb_sram_dp_tiled.sv
// Scoreboard bench: three instances (OUT_REG 1/0, DEPTH 64, and DEPTH 48) share stimulus;
// a byte-level array model produces expected reads, a negedge monitor pops and compares.
module tb_sram_dp_tiled;

    localparam int W  = 256;
    localparam int NB = W / 8;
    localparam int AW = 6;
    localparam int NI = 3;

    typedef struct {
        logic [W-1:0] d;
        int           due;
    } exp_t;

    logic            clk;
    logic            rst;
    logic            en_a_n, we_a_n, en_b_n, we_b_n;
    logic [NB-1:0]   mask_a, mask_b;
    logic [AW-1:0]   addr_a, addr_b;
    logic [W-1:0]    data_a, data_b;

    logic            rdy   [NI];
    logic [W-1:0]    q_a   [NI];
    logic [W-1:0]    q_b   [NI];
    logic            qv_a  [NI];
    logic            qv_b  [NI];

    int   DEP  [NI] = '{64, 64, 48};
    int   OREG [NI] = '{1, 0, 1};
    logic [W-1:0] mem [NI][64];
    int   fill_n [NI];
    logic exp_ready [NI];
    exp_t sb [2*NI][$];

    int   edge_n = 0;
    int   n_vec  = 0;
    int   n_err  = 0;
    logic mon_en = 1'b0;

    sram_dp_tiled #(.WIDTH(W), .DEPTH(64), .MACRO_WIDTH(64), .OUT_REG(1)) u0 (
        .clk(clk), .rst(rst), .ready(rdy[0]),
        .enable_a_n(en_a_n), .write_enable_a_n(we_a_n), .mask_a(mask_a), .address_a(addr_a),
        .data_a(data_a), .q_a(q_a[0]), .q_a_valid(qv_a[0]),
        .enable_b_n(en_b_n), .write_enable_b_n(we_b_n), .mask_b(mask_b), .address_b(addr_b),
        .data_b(data_b), .q_b(q_b[0]), .q_b_valid(qv_b[0]));

    sram_dp_tiled #(.WIDTH(W), .DEPTH(64), .MACRO_WIDTH(64), .OUT_REG(0)) u1 (
        .clk(clk), .rst(rst), .ready(rdy[1]),
        .enable_a_n(en_a_n), .write_enable_a_n(we_a_n), .mask_a(mask_a), .address_a(addr_a),
        .data_a(data_a), .q_a(q_a[1]), .q_a_valid(qv_a[1]),
        .enable_b_n(en_b_n), .write_enable_b_n(we_b_n), .mask_b(mask_b), .address_b(addr_b),
        .data_b(data_b), .q_b(q_b[1]), .q_b_valid(qv_b[1]));

    sram_dp_tiled #(.WIDTH(W), .DEPTH(48), .MACRO_WIDTH(64), .OUT_REG(1)) u2 (
        .clk(clk), .rst(rst), .ready(rdy[2]),
        .enable_a_n(en_a_n), .write_enable_a_n(we_a_n), .mask_a(mask_a), .address_a(addr_a),
        .data_a(data_a), .q_a(q_a[2]), .q_a_valid(qv_a[2]),
        .enable_b_n(en_b_n), .write_enable_b_n(we_b_n), .mask_b(mask_b), .address_b(addr_b),
        .data_b(data_b), .q_b(q_b[2]), .q_b_valid(qv_b[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] rd_model(input int i, input logic [AW-1:0] a);
        if (int'(a) < DEP[i]) return mem[i][a];
        return '0;
    endfunction

    task automatic wr_model(input int i, input logic [AW-1:0] a, input logic [NB-1:0] m,
                            input logic [W-1:0] d);
        if (int'(a) < DEP[i]) begin
            for (int k = 0; k < NB; k++)
                if (m[k]) mem[i][a][k*8 +: 8] = d[k*8 +: 8];
        end
    endtask

    task automatic push_exp(input int k, input logic [W-1:0] d, input int due);
        exp_t e;
        e.d   = d;
        e.due = due;
        sb[k].push_back(e);
    endtask

    // One clock edge: the model consumes the inputs the DUTs just sampled.
    task automatic step();
        @(posedge clk);
        edge_n++;
        for (int i = 0; i < NI; i++) begin
            if (rst) begin
                fill_n[i]    = 0;
                exp_ready[i] = 1'b0;
                sb[2*i].delete();
                sb[2*i+1].delete();
                for (int a = 0; a < 64; a++) mem[i][a] = '0;
            end else begin
                if (fill_n[i] >= DEP[i]) begin
                    if (!en_a_n && we_a_n) push_exp(2*i,   rd_model(i, addr_a), edge_n + OREG[i]);
                    if (!en_b_n && we_b_n) push_exp(2*i+1, rd_model(i, addr_b), edge_n + OREG[i]);
                    if (!en_b_n && !we_b_n) wr_model(i, addr_b, mask_b, data_b);
                    if (!en_a_n && !we_a_n) wr_model(i, addr_a, mask_a, data_a);
                end
                if (fill_n[i] < 1000) fill_n[i]++;
                exp_ready[i] = (fill_n[i] >= DEP[i]);
            end
        end
        #1;
    endtask

    task automatic set_a(input logic req, input logic wr, input logic [AW-1:0] a,
                         input logic [NB-1:0] m, input logic [W-1:0] d);
        en_a_n = ~req; we_a_n = ~wr; addr_a = a; mask_a = m; data_a = d;
    endtask

    task automatic set_b(input logic req, input logic wr, input logic [AW-1:0] a,
                         input logic [NB-1:0] m, input logic [W-1:0] d);
        en_b_n = ~req; we_b_n = ~wr; addr_b = a; mask_b = m; data_b = d;
    endtask

    task automatic idle(input int n);
        set_a(1'b0, 1'b0, 6'd0, '0, '0);
        set_b(1'b0, 1'b0, 6'd0, '0, '0);
        for (int c = 0; c < n; c++) step();
    endtask

    function automatic logic [W-1:0] rnd_word();
        logic [W-1:0] w;
        for (int k = 0; k < W / 32; k++) w[k*32 +: 32] = $urandom();
        return w;
    endfunction

    function automatic logic [NB-1:0] rnd_mask();
        case ($urandom_range(0, 3))
            0:       return {NB{1'b1}};
            1:       return {NB{1'b0}};
            default: return NB'($urandom());
        endcase
    endfunction

    function automatic logic [AW-1:0] rnd_addr();
        if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 3));
        return AW'($urandom_range(0, 63));
    endfunction

    task automatic rand_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            set_a($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, rnd_addr(), rnd_mask(), rnd_word());
            set_b($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, rnd_addr(), rnd_mask(), rnd_word());
            step();
        end
    endtask

    task automatic check_reset_outputs();
        for (int i = 0; i < NI; i++) begin
            n_vec++;
            if (rdy[i] !== 1'b0 || qv_a[i] !== 1'b0 || qv_b[i] !== 1'b0 || q_a[i] !== '0 || q_b[i] !== '0) begin
                n_err++;
                $display("FAIL reset_state dut%0d: ready=%b va=%b vb=%b q_a=%h q_b=%h, required all zero",
                         i, rdy[i], qv_a[i], qv_b[i], q_a[i], q_b[i]);
            end
        end
    endtask

    // Monitor: pop an expected entry whenever a DUT presents read data
    always @(negedge clk) begin
        logic         v;
        logic [W-1:0] d;
        exp_t         e;
        int           k;
        if (mon_en) begin
            for (int i = 0; i < NI; i++) begin
                n_vec++;
                if (rdy[i] !== exp_ready[i]) begin
                    n_err++;
                    $display("FAIL ready dut%0d edge %0d: got %b required %b", i, edge_n, rdy[i], exp_ready[i]);
                end
                for (int p = 0; p < 2; p++) begin
                    k = 2*i + p;
                    v = (p == 1) ? qv_b[i] : qv_a[i];
                    d = (p == 1) ? q_b[i]  : q_a[i];
                    while (sb[k].size() > 0 && sb[k][0].due < edge_n) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL missing_valid dut%0d port%0d: no valid at edge %0d, required one",
                                 i, p, sb[k][0].due);
                        void'(sb[k].pop_front());
                    end
                    if (v !== 1'b0) begin
                        n_vec++;
                        if (sb[k].size() == 0) begin
                            n_err++;
                            $display("FAIL unexpected_valid dut%0d port%0d edge %0d: valid=%b data=%h, required no read",
                                     i, p, edge_n, v, d);
                        end else begin
                            e = sb[k].pop_front();
                            if (e.due != edge_n || d !== e.d) begin
                                n_err++;
                                $display("FAIL read_data dut%0d port%0d: got %h at edge %0d, required %h at edge %0d",
                                         i, p, d, edge_n, e.d, e.due);
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        set_a(1'b0, 1'b0, 6'd0, '0, '0);
        set_b(1'b0, 1'b0, 6'd0, '0, '0);
        step();
        rst = 1'b0;
        mon_en = 1'b1;
        check_reset_outputs();
        idle(70);

        // Sweep every address on both ports after zero-fill
        for (int a = 0; a < 64; a++) begin
            set_a(1'b1, 1'b0, AW'(a), '0, '0);
            set_b(1'b1, 1'b0, AW'(63 - a), '0, '0);
            step();
        end
        idle(3);

        // Full write then cross-port read of the same word
        set_a(1'b1, 1'b1, 6'd5, {NB{1'b1}}, {32{8'hA5}});
        step();
        set_a(1'b0, 1'b0, 6'd0, '0, '0);
        set_b(1'b1, 1'b0, 6'd5, '0, '0);
        step();
        idle(3);

        // Single-byte mask
        set_a(1'b1, 1'b1, 6'd9, {{(NB-1){1'b0}}, 1'b1}, {W{1'b1}});
        step();
        set_a(1'b1, 1'b0, 6'd9, '0, '0);
        step();
        idle(3);

        // Same-address double write: A wins where its mask is set
        set_a(1'b1, 1'b1, 6'd3, {{(NB/2){1'b0}}, {(NB/2){1'b1}}}, {32{8'h11}});
        set_b(1'b1, 1'b1, 6'd3, {NB{1'b1}}, {32{8'h22}});
        step();
        set_a(1'b1, 1'b0, 6'd3, '0, '0);
        set_b(1'b0, 1'b0, 6'd0, '0, '0);
        step();
        idle(3);

        // Read-old on write/read collision, then the new value
        set_a(1'b1, 1'b1, 6'd7, {NB{1'b1}}, {32{8'h33}});
        step();
        set_a(1'b1, 1'b1, 6'd7, {NB{1'b1}}, {32{8'h44}});
        set_b(1'b1, 1'b0, 6'd7, '0, '0);
        step();
        set_a(1'b0, 1'b0, 6'd0, '0, '0);
        set_b(1'b1, 1'b0, 6'd7, '0, '0);
        step();
        idle(3);

        rand_cycles(400);

        // Reset with reads in flight, then reset again mid-fill
        set_a(1'b1, 1'b0, rnd_addr(), '0, '0);
        set_b(1'b1, 1'b0, rnd_addr(), '0, '0);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_outputs();
        rand_cycles(30);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_outputs();
        rand_cycles(80);
        rand_cycles(300);
        idle(5);

        for (int k = 0; k < 2*NI; k++) begin
            n_vec++;
            if (sb[k].size() != 0) begin
                n_err++;
                $display("FAIL drain queue%0d: %0d reads outstanding, required 0", k, sb[k].size());
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
